// File: rtl/blob_bbox_accumulator.sv
// Per-label bounding-box and pixel-count accumulator for a connected-components label stream.
// The table is a write-first synchronous-read memory; records drain over valid/ready at frame end.
module blob_bbox_accumulator #(
  parameter int unsigned LABEL_W = 8,
  parameter int unsigned COORD_W = 11,
  parameter int unsigned COUNT_W = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [LABEL_W-1:0] pix_label,
  input  logic               frame_end,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LABEL_W-1:0] out_label,
  output logic [COORD_W-1:0] out_min_x,
  output logic [COORD_W-1:0] out_max_x,
  output logic [COORD_W-1:0] out_min_y,
  output logic [COORD_W-1:0] out_max_y,
  output logic [COUNT_W-1:0] out_count,
  output logic               busy,
  output logic               frame_done,
  output logic               dropped
);

  localparam int unsigned NUM_LABELS = 2 ** LABEL_W;

  typedef struct packed {
    logic [COUNT_W-1:0] count;
    logic [COORD_W-1:0] min_x;
    logic [COORD_W-1:0] max_x;
    logic [COORD_W-1:0] min_y;
    logic [COORD_W-1:0] max_y;
  } entry_t;

  typedef enum logic [1:0] {StClear, StAccum, StDump} state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic [LABEL_W-1:0] r_idx;
  logic               r_rd_ok;
  logic               r_scan_done;

  entry_t             r_mem [NUM_LABELS];
  entry_t             r_rd_data;

  logic               r_p_valid;
  logic [LABEL_W-1:0] r_p_label;
  logic [COORD_W-1:0] r_p_x;
  logic [COORD_W-1:0] r_p_y;

  logic               r_out_valid;
  logic [LABEL_W-1:0] r_out_label;
  entry_t             r_out_entry;
  logic               r_frame_done;
  logic               r_dropped;

  entry_t             w_empty;
  entry_t             w_merge;
  entry_t             w_wd;
  logic               w_we;
  logic [LABEL_W-1:0] w_wa;
  logic [LABEL_W-1:0] w_rd_addr;
  logic               w_free;
  logic               w_hs;
  logic               w_cand_full;

  assign w_free      = !r_out_valid || out_ready;
  assign w_hs        = r_out_valid && out_ready;
  assign w_cand_full = (r_rd_data.count != '0);

  always_comb begin
    w_empty       = '0;
    w_empty.min_x = '1;
    w_empty.min_y = '1;
  end

  always_comb begin
    w_merge       = r_rd_data;
    w_merge.min_x = (r_p_x < r_rd_data.min_x) ? r_p_x : r_rd_data.min_x;
    w_merge.max_x = (r_p_x > r_rd_data.max_x) ? r_p_x : r_rd_data.max_x;
    w_merge.min_y = (r_p_y < r_rd_data.min_y) ? r_p_y : r_rd_data.min_y;
    w_merge.max_y = (r_p_y > r_rd_data.max_y) ? r_p_y : r_rd_data.max_y;
    w_merge.count = (&r_rd_data.count) ? r_rd_data.count : r_rd_data.count + 1'b1;
  end

  always_comb begin
    w_state_d = r_state;
    w_rd_addr = pix_label;
    w_we      = 1'b0;
    w_wa      = r_idx;
    w_wd      = w_empty;
    case (r_state)
      StClear: begin
        w_we = 1'b1;
        if (&r_idx) w_state_d = StAccum;
      end
      StAccum: begin
        if (frame_end) w_state_d = StDump;
      end
      StDump: begin
        // Prefetch the next index only when the current candidate is being consumed.
        if (r_rd_ok && w_free && !r_scan_done) w_rd_addr = r_idx + 1'b1;
        else                                   w_rd_addr = r_idx;
        if (r_scan_done && w_free) w_state_d = StAccum;
      end
      default: w_state_d = StClear;
    endcase
    if (r_p_valid) begin
      w_we = 1'b1;
      w_wa = r_p_label;
      w_wd = w_merge;
    end else if (w_hs) begin
      w_we = 1'b1;
      w_wa = r_out_label;
      w_wd = w_empty;
    end
  end

  // Write-first bypass forwards a same-address update to the next read-modify-write.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wa] <= w_wd;
    r_rd_data <= (w_we && (w_wa == w_rd_addr)) ? w_wd : r_mem[w_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StClear;
      r_idx        <= '0;
      r_rd_ok      <= 1'b0;
      r_scan_done  <= 1'b0;
      r_p_valid    <= 1'b0;
      r_p_label    <= '0;
      r_p_x        <= '0;
      r_p_y        <= '0;
      r_out_valid  <= 1'b0;
      r_out_label  <= '0;
      r_out_entry  <= '0;
      r_frame_done <= 1'b0;
      r_dropped    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_frame_done <= 1'b0;
      r_p_valid    <= (r_state == StAccum) && pix_valid && (pix_label != '0);
      r_p_label    <= pix_label;
      r_p_x        <= pix_x;
      r_p_y        <= pix_y;
      if ((pix_valid || frame_end) && (r_state != StAccum)) r_dropped <= 1'b1;
      case (r_state)
        StClear: r_idx <= r_idx + 1'b1;
        StAccum: begin
          if (frame_end) begin
            r_idx       <= LABEL_W'(1);
            r_rd_ok     <= 1'b0;
            r_scan_done <= 1'b0;
          end
        end
        StDump: begin
          if (!r_rd_ok) begin
            r_rd_ok <= 1'b1;
          end else if (r_scan_done) begin
            if (w_free) begin
              r_out_valid  <= 1'b0;
              r_frame_done <= 1'b1;
            end
          end else if (w_free) begin
            r_out_valid <= w_cand_full;
            if (w_cand_full) begin
              r_out_label <= r_idx;
              r_out_entry <= r_rd_data;
            end
            r_idx <= r_idx + 1'b1;
            if (&r_idx) r_scan_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_label  = r_out_label;
  assign out_min_x  = r_out_entry.min_x;
  assign out_max_x  = r_out_entry.max_x;
  assign out_min_y  = r_out_entry.min_y;
  assign out_max_y  = r_out_entry.max_y;
  assign out_count  = r_out_entry.count;
  assign busy       = (r_state != StAccum);
  assign frame_done = r_frame_done;
  assign dropped    = r_dropped;

endmodule

// File: tb/tb_blob_bbox_accumulator.sv
// Scoreboard bench: stimulus pushes expected records, a negedge monitor pops them on handshake.
module tb_blob_bbox_accumulator;

  localparam int unsigned LW = 8;
  localparam int unsigned XW = 11;
  localparam int unsigned NW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          pix_valid;
  logic [XW-1:0] pix_x;
  logic [XW-1:0] pix_y;
  logic [LW-1:0] pix_label;
  logic          frame_end;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_label;
  logic [XW-1:0] out_min_x;
  logic [XW-1:0] out_max_x;
  logic [XW-1:0] out_min_y;
  logic [XW-1:0] out_max_y;
  logic [NW-1:0] out_count;
  logic          busy;
  logic          frame_done;
  logic          dropped;

  blob_bbox_accumulator #(
    .LABEL_W(LW),
    .COORD_W(XW),
    .COUNT_W(NW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_label (pix_label),
    .frame_end (frame_end),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_label (out_label),
    .out_min_x (out_min_x),
    .out_max_x (out_max_x),
    .out_min_y (out_min_y),
    .out_max_y (out_max_y),
    .out_count (out_count),
    .busy      (busy),
    .frame_done(frame_done),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int label;
    int min_x;
    int max_x;
    int min_y;
    int max_y;
    int count;
  } rec_t;

  rec_t exp_q[$];
  rec_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   n_rec = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int l, input int x0, input int x1, input int y0, input int y1,
                      input int c);
    rec_t r;
    r.label = l; r.min_x = x0; r.max_x = x1; r.min_y = y0; r.max_y = y1; r.count = c;
    exp_q.push_back(r);
  endtask

  task automatic pix(input int l, input int x, input int y, input bit fe);
    pix_valid = 1'b1;
    pix_label = LW'(l);
    pix_x     = XW'(x);
    pix_y     = XW'(y);
    frame_end = fe;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic fend();
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    chk({name, "_frame_done_seen"}, int'(seen), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk({name, "_out_valid_seen"}, int'(seen), 1);
  endtask

  // Counts consecutive busy samples starting at the first negedge after the reset edge.
  task automatic measure_clear(input string name);
    int n = 0;
    bit vseen = 1'b0;
    bit done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (out_valid) vseen = 1'b1;
      if (busy) n++;
      else done = 1'b1;
    end
    chk({name, "_busy_cycles"}, n, 256);
    chk({name, "_no_valid_in_clear"}, int'(vseen), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        n_rec++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_record: got label %0d expected none", out_label);
        end else begin
          mon_e = exp_q.pop_front();
          if (int'(out_label) != mon_e.label || int'(out_min_x) != mon_e.min_x ||
              int'(out_max_x) != mon_e.max_x || int'(out_min_y) != mon_e.min_y ||
              int'(out_max_y) != mon_e.max_y || int'(out_count) != mon_e.count) begin
            bad++;
            $display("FAIL record: got l=%0d (%0d,%0d,%0d,%0d,c%0d) expected l=%0d (%0d,%0d,%0d,%0d,c%0d)",
                     out_label, out_min_x, out_max_x, out_min_y, out_max_y, out_count,
                     mon_e.label, mon_e.min_x, mon_e.max_x, mon_e.min_y, mon_e.max_y,
                     mon_e.count);
          end
        end
      end
      if (frame_done) begin
        total++;
        if (exp_q.size() != 0) begin
          bad++;
          $display("FAIL frame_done_pending: got %0d records outstanding expected 0",
                   exp_q.size());
        end
      end
    end
  end

  initial begin
    int n0;
    reset     = 1'b1;
    pix_valid = 1'b0;
    pix_x     = '0;
    pix_y     = '0;
    pix_label = '0;
    frame_end = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 1);
    chk("reset_out_min_x", int'(out_min_x), 0);
    reset = 1'b0;
    measure_clear("startup");
    chk("dropped_after_startup", int'(dropped), 0);

    // Two blobs, streamed
    push(1, 100, 100, 200, 200, 1);
    push(3, 10, 12, 5, 7, 3);
    pix(3, 10, 5, 0); pix(3, 12, 7, 0); pix(3, 11, 6, 0); pix(1, 100, 200, 0);
    fend();
    wait_done("two_blobs");
    chk("two_blobs_busy_after", int'(busy), 0);

    // Same-label burst
    push(7, 0, 4, 9, 9, 5);
    for (int i = 0; i < 5; i++) pix(7, i, 9, 0);
    fend();
    wait_done("burst");

    // Backpressure: label 1 must hold while out_ready is low
    out_ready = 1'b0;
    push(1, 100, 100, 200, 200, 1);
    push(3, 10, 12, 5, 7, 3);
    pix(3, 10, 5, 0); pix(3, 12, 7, 0); pix(3, 11, 6, 0); pix(1, 100, 200, 0);
    fend();
    wait_valid("bp");
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_label", int'(out_label), 1);
      chk("bp_hold_min_x", int'(out_min_x), 100);
      chk("bp_hold_max_y", int'(out_max_y), 200);
      chk("bp_hold_count", int'(out_count), 1);
      chk("bp_hold_busy", int'(busy), 1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done("bp");
    n0 = n_rec;
    fend();
    wait_done("bp_next");
    chk("bp_next_records", n_rec - n0, 0);

    // Pixel coincident with frame_end, then a pixel during dump
    chk("dropped_before_drop", int'(dropped), 0);
    push(9, 7, 7, 8, 8, 1);
    pix(9, 7, 8, 1);
    pix(4, 50, 50, 0);
    wait_done("coincide");
    chk("dropped_after_dump_pixel", int'(dropped), 1);
    n0 = n_rec;
    fend();
    wait_done("no_stale");
    chk("no_stale_records", n_rec - n0, 0);

    // Saturation plus all-ones coordinate
    push(2, 0, 19, 1, 1, 15);
    push(255, 2047, 2047, 2047, 2047, 1);
    for (int i = 0; i < 20; i++) pix(2, i, 1, 0);
    pix(255, 2047, 2047, 0);
    fend();
    wait_done("saturate");

    // Reset mid-dump discards pending records
    out_ready = 1'b0;
    pix(5, 1, 1, 0); pix(6, 2, 2, 0);
    fend();
    wait_valid("rst_dump");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    measure_clear("rst_dump");
    chk("dropped_cleared_by_reset", int'(dropped), 0);
    n0 = n_rec;
    fend();
    wait_done("post_reset");
    chk("post_reset_records", n_rec - n0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/blob_bbox_accumulator.md
Name: blob_bbox_accumulator

Overview:
- Sits directly downstream of connected-components labelling and consumes its per-pixel label stream with pixel coordinates.
- Per frame, accumulates for every non-zero label a bounding box (min/max x, min/y) and a pixel count.
- At frame end, drains the non-empty records over a valid/ready interface and clears the table for the next frame.

Parameters:
- LABEL_W, 8, label width; table depth NUM_LABELS = 2^LABEL_W; label 0 is background.
- COORD_W, 11, width of x/y coordinates.
- COUNT_W, 20, width of per-label pixel count; saturates.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- pix_valid  in  1  pixel present this cycle
- pix_x  in  COORD_W  column of pixel
- pix_y  in  COORD_W  row of pixel
- pix_label  in  LABEL_W  label from CC stage; 0 = background
- frame_end  in  1  one-cycle pulse; last pixel of frame has been presented
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts record
- out_label  out  LABEL_W  label of record
- out_min_x  out  COORD_W  bounding-box left column
- out_max_x  out  COORD_W  bounding-box right column
- out_min_y  out  COORD_W  bounding-box top row
- out_max_y  out  COORD_W  bounding-box bottom row
- out_count  out  COUNT_W  pixels carrying this label
- busy  out  1  high in CLEAR or DUMP
- frame_done  out  1  one-cycle pulse when a dump completes
- dropped  out  1  sticky; a pixel or frame_end arrived while not in ACCUM

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: out_valid=0, frame_done=0, dropped=0, busy=1, all out_* data=0. The state machine enters CLEAR.

States:
- CLEAR
  - Writes the empty entry to one index per cycle, indices 0..NUM_LABELS-1, so it lasts NUM_LABELS cycles.
  - Empty entry: count=0, min_x=min_y=all-ones, max_x=max_y=0.
  - Then goes to ACCUM.
- ACCUM
  - On pix_valid with pix_label!=0, entry[label] is updated:
    - min_x=min(min_x,pix_x) and min_y=min(min_y,pix_y).
    - max_x=max(max_x,pix_x) and max_y=max(max_y,pix_y).
    - count=count+1, saturating at 2^COUNT_W-1.
  - Back-to-back pixels with the same label must accumulate correctly, with no lost updates. The read-modify-write path must forward.
  - pix_label==0 is ignored.
  - On frame_end, go to DUMP. A pix_valid in the same cycle as frame_end is accumulated before the dump.
- DUMP
  - An index pointer scans 1..NUM_LABELS-1 in ascending order.
  - Empty entry (count==0): skip it in exactly one cycle.
  - Non-empty entry: load the output registers and assert out_valid.
  - out_* are held stable while out_valid=1 and out_ready=0.
  - On handshake (out_valid && out_ready): that entry is reset to the empty entry and the pointer advances.
  - A new record may be presented in the cycle after a handshake.
  - After index NUM_LABELS-1 is retired: frame_done pulses one cycle, busy falls, and the state returns to ACCUM.
  - The table is fully empty on return, so no separate CLEAR pass is needed.

Boundary conditions:
- pix_valid or frame_end during CLEAR or DUMP: the input is ignored and dropped is set. dropped is cleared only by reset.
- frame_end with no labelled pixels: DUMP runs NUM_LABELS-1 cycles with no out_valid, then frame_done.
- Single-pixel blob: min==max on both axes, count=1.
- Coordinate all-ones: accepted as a legal coordinate.
- out_ready held high: records stream at up to one per cycle.
- out_ready stuck low: stalls indefinitely, busy stays 1, no data is lost.
- Reset mid-DUMP or mid-ACCUM: out_valid drops the next cycle, remaining records are discarded, and the block re-enters CLEAR.

Test Plan:
- Startup timing: reset 1 cycle, then wait. busy=1 for exactly 256 cycles (LABEL_W=8), then busy=0, and out_valid is never asserted in that window.
- Two blobs:
  - Stimulus: label 3 at (10,5), (12,7), (11,6); label 1 at (100,200); then frame_end; out_ready=1.
  - Response: record label 1 (100,100,200,200,count 1), then label 3 (10,12,5,7,count 3), then frame_done.
  - Records are in label order; data fields are listed as (min_x,max_x,min_y,max_y,count).
- Same-label burst: 5 consecutive cycles of label 7 at x=0..4, y=9 -> record (0,4,9,9,count 5), with no lost update.
- Backpressure: same stimulus as the two-blob test, with out_ready low for 10 cycles after the first out_valid. The label 1 record is held unchanged for those 10 cycles. Both records are then delivered, and the next frame's dump emits nothing stale.
- Drop and coincidence:
  - pix_valid in the same cycle as frame_end: that pixel is included in the dump.
  - pix_valid during DUMP: ignored, and dropped=1.
- Saturation and reset: with COUNT_W=4, 20 pixels of label 2 -> out_count=15. Assert reset mid-dump: out_valid=0 next cycle, busy=1 for 256 cycles.
